// File: rtl/stim_gen_74299.sv
// Stimulus generator for a 74299 universal shift register under test.
// Sequences load / shift-right / hold / shift-left and tracks the expected parallel output.
module stim_gen_74299 #(
    parameter logic [7:0] SEED    = 8'hAA,
    parameter logic [7:0] SER_PAT = 8'h55,
    parameter int         SHIFTS  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stall,
    output logic       s1,
    output logic       s0,
    output logic       dsr,
    output logic       dsl,
    output logic [7:0] load_data,
    output logic       oe_n,
    output logic       busy,
    output logic       done,
    output logic [7:0] expected,
    output logic       exp_valid
);

    typedef enum logic [2:0] {IDLE, LOAD, SHR, HOLD, SHL, DONE} state_t;

    localparam logic [2:0] LAST_SHIFT = 3'(SHIFTS - 1);
    localparam logic [2:0] LAST_HOLD  = 3'd1;

    state_t     state, state_nx;
    logic [2:0] k, k_nx;
    logic [7:0] m, m_nx;
    logic       ev_nx;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_nx  = state;
        k_nx      = k;
        m_nx      = m;
        s1        = 1'b0;
        s0        = 1'b0;
        dsr       = 1'b0;
        dsl       = 1'b0;
        load_data = 8'h00;
        oe_n      = (state == IDLE);
        busy      = (state != IDLE);
        done      = (state == DONE);
        ev_nx     = (state inside {LOAD, SHR, HOLD, SHL});

        // A stalled sequence issues a hold command and freezes state, k and m.
        if (!(stall && state != IDLE)) begin
            case (state)
                IDLE: begin
                    if (start) state_nx = LOAD;
                end
                LOAD: begin
                    s1        = 1'b1;
                    s0        = 1'b1;
                    load_data = SEED;
                    m_nx      = SEED;
                    state_nx  = SHR;
                end
                SHR: begin
                    s0   = 1'b1;
                    dsr  = SER_PAT[k];
                    m_nx = {SER_PAT[k], m[7:1]};
                    if (k == LAST_SHIFT) begin
                        state_nx = HOLD;
                        k_nx     = 3'd0;
                    end else begin
                        k_nx = k + 3'd1;
                    end
                end
                HOLD: begin
                    if (k == LAST_HOLD) begin
                        state_nx = SHL;
                        k_nx     = 3'd0;
                    end else begin
                        k_nx = k + 3'd1;
                    end
                end
                SHL: begin
                    s1   = 1'b1;
                    dsl  = ~SER_PAT[k];
                    m_nx = {m[6:0], ~SER_PAT[k]};
                    if (k == LAST_SHIFT) begin
                        state_nx = DONE;
                        k_nx     = 3'd0;
                    end else begin
                        k_nx = k + 3'd1;
                    end
                end
                DONE: begin
                    state_nx = IDLE;
                end
                default: begin
                    state_nx = IDLE;
                    k_nx     = 3'd0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the model register is reset explicitly; the bench compares it right after reset.
            state     <= IDLE;
            k         <= 3'd0;
            m         <= 8'h00;
            exp_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            k         <= k_nx;
            m         <= m_nx;
            exp_valid <= ev_nx;
        end
    end

    // m already holds the post-edge result, which is what the DUT shows one cycle after the command.
    assign expected = m;

endmodule

// File: tb/tb_stim_gen_74299.sv
// Self-checking bench for stim_gen_74299: vector table for control outputs,
// scoreboard queues for the expected/exp_valid stream of two parameterisations.
module tb_stim_gen_74299;

    logic clk = 1'b0;
    logic rst, start, stall, start1, stall1;
    always #5 clk = ~clk;

    logic       s1, s0, dsr, dsl, oe_n, busy, done, exp_valid;
    logic [7:0] load_data, expected;
    logic       b_s1, b_s0, b_dsr, b_dsl, b_oe_n, b_busy, b_done, b_exp_valid;
    logic [7:0] b_load_data, b_expected;

    stim_gen_74299 dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .s1(s1), .s0(s0), .dsr(dsr), .dsl(dsl), .load_data(load_data),
        .oe_n(oe_n), .busy(busy), .done(done),
        .expected(expected), .exp_valid(exp_valid)
    );

    stim_gen_74299 #(.SEED(8'h0F), .SER_PAT(8'h01), .SHIFTS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .stall(stall1),
        .s1(b_s1), .s0(b_s0), .dsr(b_dsr), .dsl(b_dsl), .load_data(b_load_data),
        .oe_n(b_oe_n), .busy(b_busy), .done(b_done),
        .expected(b_expected), .exp_valid(b_exp_valid)
    );

    typedef struct {
        logic       start;
        logic       stall;
        logic [1:0] s;
        logic       dsr;
        logic       dsl;
        logic [7:0] ld;
        logic       oe_n;
        logic       busy;
        logic       done;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic sl, input logic [1:0] s,
                                input logic r, input logic l, input logic [7:0] ld,
                                input logic oe, input logic b, input logic d);
        vec_t v;
        v.start = st; v.stall = sl; v.s = s; v.dsr = r; v.dsl = l;
        v.ld = ld; v.oe_n = oe; v.busy = b; v.done = d;
        return v;
    endfunction

    // Behavioural model of the expected stream; entry rep_idx is repeated rep_n extra
    // times (stall), and only the first 'limit' entries are queued (reset mid-run).
    task automatic model_run(input int which, input int rep_idx, input int rep_n, input int limit);
        logic [7:0] seed, pat, m;
        int sh;
        logic [7:0] list[$];
        if (which == 0) begin seed = 8'hAA; pat = 8'h55; sh = 4; end
        else            begin seed = 8'h0F; pat = 8'h01; sh = 1; end
        m = seed;
        list.push_back(m);
        for (int i = 0; i < sh; i++) begin m = {pat[i], m[7:1]}; list.push_back(m); end
        list.push_back(m);
        list.push_back(m);
        for (int i = 0; i < sh; i++) begin m = {m[6:0], ~pat[i]}; list.push_back(m); end
        for (int i = 0; i < list.size() && i < limit; i++) begin
            if (which == 0) q0.push_back(list[i]); else q1.push_back(list[i]);
            if (i == rep_idx)
                for (int j = 0; j < rep_n; j++) q0.push_back(list[i]);
        end
    endtask

    // Scoreboard monitors: pop one expected value per exp_valid cycle.
    always @(negedge clk) begin
        if (exp_valid) begin
            if (q0.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL sb0_extra: got exp_valid=1 expected=%0h want no output", expected);
            end else check("sb0_expected", 32'(expected), 32'(q0.pop_front()));
        end
        if (b_exp_valid) begin
            if (q1.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL sb1_extra: got exp_valid=1 expected=%0h want no output", b_expected);
            end else check("sb1_expected", 32'(b_expected), 32'(q1.pop_front()));
        end
    end

    task automatic apply(input vec_t v);
        start = v.start;
        stall = v.stall;
        #1;
        check("s1s0", {30'd0, s1, s0}, {30'd0, v.s});
        check("dsr", 32'(dsr), 32'(v.dsr));
        check("dsl", 32'(dsl), 32'(v.dsl));
        check("load_data", 32'(load_data), 32'(v.ld));
        check("oe_n", 32'(oe_n), 32'(v.oe_n));
        check("busy", 32'(busy), 32'(v.busy));
        check("done", 32'(done), 32'(v.done));
        @(negedge clk);
    endtask

    task automatic run_table();
        model_run(0, -1, 0, 100);
        foreach (vecs[i]) apply(vecs[i]);
        start = 1'b0;
        check("q0_drained", 32'(q0.size()), 32'd0);
    endtask

    initial begin
        int done_cycle, done_cnt;

        vecs[0]  = mk(1, 0, 2'b00, 0, 0, 8'h00, 1, 0, 0);
        vecs[1]  = mk(0, 0, 2'b11, 0, 0, 8'hAA, 0, 1, 0);
        vecs[2]  = mk(0, 0, 2'b01, 1, 0, 8'h00, 0, 1, 0);
        vecs[3]  = mk(0, 0, 2'b01, 0, 0, 8'h00, 0, 1, 0);
        vecs[4]  = mk(0, 0, 2'b01, 1, 0, 8'h00, 0, 1, 0);
        vecs[5]  = mk(0, 0, 2'b01, 0, 0, 8'h00, 0, 1, 0);
        vecs[6]  = mk(0, 0, 2'b00, 0, 0, 8'h00, 0, 1, 0);
        vecs[7]  = mk(0, 0, 2'b00, 0, 0, 8'h00, 0, 1, 0);
        vecs[8]  = mk(0, 0, 2'b10, 0, 0, 8'h00, 0, 1, 0);
        vecs[9]  = mk(0, 0, 2'b10, 0, 1, 8'h00, 0, 1, 0);
        vecs[10] = mk(0, 0, 2'b10, 0, 0, 8'h00, 0, 1, 0);
        vecs[11] = mk(0, 0, 2'b10, 0, 1, 8'h00, 0, 1, 0);
        vecs[12] = mk(0, 0, 2'b00, 0, 0, 8'h00, 0, 1, 1);
        vecs[13] = mk(0, 0, 2'b00, 0, 0, 8'h00, 1, 0, 0);

        rst = 1'b1; start = 1'b0; stall = 1'b0; start1 = 1'b0; stall1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_expected", 32'(expected), 32'h00);
        check("rst_exp_valid", 32'(exp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_oe_n", 32'(oe_n), 32'd1);
        check("rst_s1s0", {30'd0, s1, s0}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Default run from the table.
        run_table();

        // Start together with stall in IDLE, then a 3-cycle stall after the second shift result.
        model_run(0, 2, 3, 100);
        apply(mk(1, 1, 2'b00, 0, 0, 8'h00, 1, 0, 0));
        apply(mk(0, 0, 2'b11, 0, 0, 8'hAA, 0, 1, 0));
        apply(mk(0, 0, 2'b01, 1, 0, 8'h00, 0, 1, 0));
        apply(mk(0, 0, 2'b01, 0, 0, 8'h00, 0, 1, 0));
        for (int i = 0; i < 3; i++) apply(mk(0, 1, 2'b00, 0, 0, 8'h00, 0, 1, 0));
        apply(mk(0, 0, 2'b01, 1, 0, 8'h00, 0, 1, 0));
        apply(mk(0, 0, 2'b01, 0, 0, 8'h00, 0, 1, 0));
        for (int i = 0; i < 6; i++) begin start = 1'b0; stall = 1'b0; @(negedge clk); end
        apply(mk(0, 0, 2'b00, 0, 0, 8'h00, 0, 1, 1));
        #1;
        check("stall_final_expected", 32'(expected), 32'hA5);
        check("stall_q0_drained", 32'(q0.size()), 32'd0);
        apply(mk(0, 1, 2'b00, 0, 0, 8'h00, 1, 0, 0));
        stall = 1'b0;

        // Start re-pulsed during SHL and again in DONE: no restart, done timing unchanged.
        model_run(0, -1, 0, 100);
        done_cycle = -1;
        done_cnt = 0;
        for (int c = 0; c < 24; c++) begin
            start = (c == 0 || c == 9 || c == 12);
            #1;
            if (done) begin done_cnt++; if (done_cycle < 0) done_cycle = c; end
            @(negedge clk);
        end
        start = 1'b0;
        check("repulse_done_cycle", 32'(done_cycle), 32'd12);
        check("repulse_done_count", 32'(done_cnt), 32'd1);
        check("repulse_busy_end", 32'(busy), 32'd0);
        check("repulse_q0_drained", 32'(q0.size()), 32'd0);

        // Reset in the first HOLD cycle, then a clean full run.
        model_run(0, -1, 0, 5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 6; c++) @(negedge clk);
        #1;
        check("hold_s1s0", {30'd0, s1, s0}, 32'd0);
        check("hold_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_oe_n", 32'(oe_n), 32'd1);
        check("midrst_exp_valid", 32'(exp_valid), 32'd0);
        check("midrst_expected", 32'(expected), 32'h00);
        check("midrst_q0_drained", 32'(q0.size()), 32'd0);
        @(negedge clk);
        run_table();

        // SHIFTS=1 parameterisation.
        model_run(1, -1, 0, 100);
        done_cycle = -1;
        for (int c = 0; c < 12; c++) begin
            start1 = (c == 0);
            #1;
            if (b_done && done_cycle < 0) done_cycle = c;
            @(negedge clk);
        end
        start1 = 1'b0;
        check("p1_done_cycle", 32'(done_cycle), 32'd6);
        check("p1_expected_final", 32'(b_expected), 32'h0E);
        check("p1_busy_end", 32'(b_busy), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
